// File: rtl/store_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : store_arbiter
// Description : Two-port arbiter/sequencer in front of a single-port 256x32
//               data store. Serialises port 0 (CPU) and port 1 (DMA/debug)
//               accesses as ACCESS + RESP pairs, drives the store address,
//               write enable and write data, registers read data and returns
//               a one-cycle acknowledge per completed access.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n              clock (store writes on falling edge), async
//                           active-low reset
//   req/we/addr/wdata/lockN per-port request, direction, address, write
//                           data and burst-lock (N = 0,1)
//   ackN, rdataN, errN      one-cycle completion pulse, registered read data,
//                           out-of-range flag (valid while ackN = 1)
//   mem_wren/adr/din        store controls, decoded from state
//   mem_dout                store asynchronous read data
//   busy                    high while in ACCESS or RESP
// Configuration
//   STORE_ARB_ROUND_ROBIN_EN  defined   : round-robin on simultaneous requests
//                             undefined : fixed priority, port 0 wins
// ============================================================================
module store_arbiter #(
    parameter int MAX_BURST  = 4,
    parameter int ADDR_LIMIT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        lock0,
    output logic        ack0,
    output logic [31:0] rdata0,
    output logic        err0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        lock1,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic        mem_wren,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        busy
);

    localparam int          BW           = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] c_BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [31:0] c_ADDR_LIMIT = 32'(ADDR_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_grant;
    logic [BW-1:0] r_burst;
    logic          r_ack0, r_ack1, r_err0, r_err1;
    logic [31:0]   r_rdata0, r_rdata1;
`ifdef STORE_ARB_ROUND_ROBIN_EN
    logic          r_ptr;   // port preferred on the next simultaneous request
`endif

    logic        w_req_g, w_we_g, w_lock_g, w_req_o;
    logic [31:0] w_addr_g, w_wdata_g;
    logic        w_in_range, w_any, w_keep, w_force_other, w_win, w_access;

    // Granted-port view of the request inputs
    assign w_req_g    = r_grant ? req1   : req0;
    assign w_req_o    = r_grant ? req0   : req1;
    assign w_we_g     = r_grant ? we1    : we0;
    assign w_lock_g   = r_grant ? lock1  : lock0;
    assign w_addr_g   = r_grant ? addr1  : addr0;
    assign w_wdata_g  = r_grant ? wdata1 : wdata0;
    assign w_in_range = (w_addr_g < c_ADDR_LIMIT);
    assign w_any      = req0 | req1;
    assign w_access   = (r_state == ST_ACCESS);

    // Locked burst continues only while below the burst limit
    assign w_keep = (r_state == ST_RESP) && w_lock_g && w_req_g && (r_burst < c_BURST_LAST);
    // Burst limit exhausted with the other port waiting: hand the grant over
    assign w_force_other = (r_state == ST_RESP) && w_lock_g && w_req_g &&
                           (r_burst >= c_BURST_LAST) && w_req_o;

    always_comb begin
        w_win = 1'b0;
        if (w_force_other) begin
            w_win = ~r_grant;
        end else if (req0 && req1) begin
`ifdef STORE_ARB_ROUND_ROBIN_EN
            w_win = r_ptr;
`else
            w_win = 1'b0;
`endif
        end else begin
            w_win = req1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= 1'b0;
            r_burst  <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
`ifdef STORE_ARB_ROUND_ROBIN_EN
            r_ptr    <= 1'b0;
`endif
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
`ifdef STORE_ARB_ROUND_ROBIN_EN
                        r_ptr   <= ~w_win;
`endif
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // mem_dout already reflects a write committed at the falling edge
                    if (r_grant) begin
                        r_ack1   <= 1'b1;
                        r_rdata1 <= w_in_range ? mem_dout : 32'd0;
                        r_err1   <= ~w_in_range;
                    end else begin
                        r_ack0   <= 1'b1;
                        r_rdata0 <= w_in_range ? mem_dout : 32'd0;
                        r_err0   <= ~w_in_range;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_keep) begin
                        r_burst <= r_burst + 1'b1;
                        r_state <= ST_ACCESS;
                    end else begin
                        r_burst <= '0;
                        if (w_any) begin
                            r_grant <= w_win;
`ifdef STORE_ARB_ROUND_ROBIN_EN
                            r_ptr   <= ~w_win;
`endif
                            r_state <= ST_ACCESS;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Store controls are pure state decode so a reset mid-ACCESS kills the write
    assign mem_wren = w_access & w_we_g & w_in_range;
    assign mem_adr  = w_access ? w_addr_g  : 32'd0;
    assign mem_din  = w_access ? w_wdata_g : 32'd0;
    assign busy     = (r_state != ST_IDLE);

    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign err0   = r_err0;
    assign err1   = r_err1;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_store_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_arbiter
// Description : Self-checking bench for store_arbiter with a behavioural
//               store, a transaction-level reference model and directed plus
//               randomised stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_arbiter;

    localparam int MAXB = 4;
`ifdef STORE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1, err0, err1, mem_wren, busy;
    logic [31:0] rdata0, rdata1, mem_adr, mem_din, mem_dout;

    int n_checks = 0;
    int n_err    = 0;

    store_arbiter #(.MAX_BURST(MAXB), .ADDR_LIMIT(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .mem_wren(mem_wren), .mem_adr(mem_adr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural store: falling-edge write, asynchronous read, known preload
    function automatic logic [31:0] pat(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    logic [31:0] store   [0:255];
    bit          written [0:255];
    always @(negedge clk) begin
        if (mem_wren) begin
            store[mem_adr[7:0]]   <= mem_din;
            written[mem_adr[7:0]] <= 1'b1;
        end
    end
    assign mem_dout = written[mem_adr[7:0]] ? store[mem_adr[7:0]] : pat(int'(mem_adr[7:0]));

    function automatic logic [31:0] cur(input int a);
        return written[a] ? store[a] : pat(a);
    endfunction

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int          last_win;
    logic [31:0] exp_rd  [2];
    logic        exp_err [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd_of(input int p);
        return (p == 1) ? rdata1 : rdata0;
    endfunction

    function automatic logic err_of(input int p);
        return (p == 1) ? err1 : err0;
    endfunction

    // One completed access as the specification describes it
    task automatic model_access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        bit inr;
        inr = (a < 32'd256);
        if (w && inr) ref_mem[a[7:0]] = d;
        exp_rd[p]  = inr ? ref_mem[a[7:0]] : 32'd0;
        exp_err[p] = ~inr;
    endtask

    task automatic model_reset();
        last_win   = 1;          // port 0 preferred after reset
        exp_rd[0]  = 32'd0;
        exp_rd[1]  = 32'd0;
        exp_err[0] = 1'b0;
        exp_err[1] = 1'b0;
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    // From IDLE, issue up to one request per port, each held until its own ack
    task automatic do_round(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                            input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                            input string tag);
        int order [2];
        int n, cyc, wren_cnt, exp_wren, p;
        logic        w [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        w[0] = w0; a[0] = a0; d[0] = d0;
        w[1] = w1; a[1] = a1; d[1] = d1;
        order[0] = 0; order[1] = 1; n = 0;
        if (r0 && r1) begin
            order[0] = RR ? (1 - last_win) : 0;
            order[1] = 1 - order[0];
            n = 2;
        end else if (r0) begin
            order[0] = 0; n = 1;
        end else if (r1) begin
            order[0] = 1; n = 1;
        end
        exp_wren = 0;
        for (int k = 0; k < n; k++)
            if (w[order[k]] && a[order[k]] < 32'd256) exp_wren++;

        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = 1'b0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = 1'b0;
        wren_cnt = 0;
        for (int k = 0; k < n; k++) begin
            p = order[k];
            cyc = 0;
            do begin
                tick();
                cyc++;
                if (mem_wren) wren_cnt++;
            end while (!(ack0 || ack1) && cyc < 12);
            model_access(p, w[p], a[p], d[p]);
            chk({tag, " latency"}, 32'(cyc), 32'd2);
            chk({tag, " ack"}, {30'd0, ack1, ack0}, (p == 1) ? 32'd2 : 32'd1);
            chk({tag, " rdata"}, rd_of(p), exp_rd[p]);
            chk({tag, " err"}, {31'd0, err_of(p)}, {31'd0, exp_err[p]});
            chk({tag, " other rdata held"}, rd_of(1 - p), exp_rd[1 - p]);
            last_win = p;
            if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        end
        tick();
        if (mem_wren) wren_cnt++;
        chk({tag, " idle"}, {31'd0, busy}, 32'd0);
        chk({tag, " wren cycles"}, 32'(wren_cnt), 32'(exp_wren));
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom | 32'h100;
        return 32'($urandom_range(0, 255));
    endfunction

    int cyc, p, nb1;
    logic rr0, rr1;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; lock0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; lock1 = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        repeat (2) tick();

        // Reset state
        chk("rst ack0", {31'd0, ack0}, 32'd0);
        chk("rst ack1", {31'd0, ack1}, 32'd0);
        chk("rst err", {30'd0, err1, err0}, 32'd0);
        chk("rst rdata0", rdata0, 32'd0);
        chk("rst rdata1", rdata1, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst mem_wren", {31'd0, mem_wren}, 32'd0);
        chk("rst mem_adr", mem_adr, 32'd0);
        chk("rst mem_din", mem_din, 32'd0);
        rst_n = 1'b1;
        tick();

        // Write then read back on port 0
        do_round(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, "wr0 0x10");
        chk("store 0x10", cur(16), 32'hDEADBEEF);
        do_round(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, "rd0 0x10");
        chk("rd0 0x10 value", rdata0, 32'hDEADBEEF);

        // Simultaneous requests held continuously from IDLE
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'h01; req1 = 1; we1 = 0; addr1 = 32'h02;
        for (int k = 0; k < 8; k++) begin
            p = RR ? (1 - last_win) : 0;
            cyc = 0;
            do begin tick(); cyc++; end while (!(ack0 || ack1) && cyc < 12);
            model_access(p, 1'b0, (p == 1) ? addr1 : addr0, 32'd0);
            chk("both ack", {30'd0, ack1, ack0}, (p == 1) ? 32'd2 : 32'd1);
            chk("both rdata", rd_of(p), exp_rd[p]);
            last_win = p;
        end
        req0 = 0; req1 = 0;
        tick();

        // Locked burst on port 1 with port 0 waiting
        req1 = 1; we1 = 1; lock1 = 1; addr1 = 32'h20; wdata1 = 32'hB000_0020;
        tick();
        req0 = 1; we0 = 0; addr0 = 32'h10; lock0 = 0;
        nb1 = 0;
        for (int k = 0; k < 7; k++) begin
            p = (k == MAXB) ? 0 : 1;
            cyc = 0;
            do begin tick(); cyc++; end while (!(ack0 || ack1) && cyc < 12);
            chk("burst ack", {30'd0, ack1, ack0}, (p == 1) ? 32'd2 : 32'd1);
            if (p == 1) model_access(1, 1'b1, addr1, wdata1);
            else        model_access(0, 1'b0, addr0, 32'd0);
            chk("burst rdata", rd_of(p), exp_rd[p]);
            last_win = p;
            if (p == 1) begin
                nb1++;
                if (nb1 == 6) begin
                    req1 = 0; lock1 = 0;
                end else begin
                    addr1 = 32'h20 + 32'(nb1); wdata1 = 32'hB000_0020 + 32'(nb1);
                end
            end else begin
                req0 = 0;
            end
        end
        tick();
        for (int i = 0; i < 6; i++) chk("burst store", cur(32 + i), ref_mem[32 + i]);

        // Out-of-range write must not alias onto word 0
        do_round(0, 0, 0, 0, 1, 1, 32'h100, 32'h1234, "oor wr1");
        chk("oor err1", {31'd0, err1}, 32'd1);
        chk("oor rdata1", rdata1, 32'd0);
        do_round(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, "rd1 0x00");
        chk("word 0 intact", rdata1, pat(0));

        // Reset asserted during ACCESS before the falling edge
        req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'hBAD0BAD0;
        tick();
        chk("abort in access", {31'd0, mem_wren}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        req0 = 0;
        model_reset();
        chk("abort mem_wren", {31'd0, mem_wren}, 32'd0);
        chk("abort mem_adr", mem_adr, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort acks", {30'd0, ack1, ack0}, 32'd0);
        chk("abort rdata0", rdata0, 32'd0);
        @(negedge clk);
        #1;
        chk("abort store 0x30", cur(48), ref_mem[48]);
        rst_n = 1'b1;
        tick();
        chk("abort idle", {31'd0, busy}, 32'd0);

        // Back-to-back reads with req0 held and address advanced in each ack cycle
        req0 = 1; we0 = 0; addr0 = 32'h0;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin tick(); cyc++; end while (!(ack0 || ack1) && cyc < 12);
            model_access(0, 1'b0, addr0, 32'd0);
            chk("b2b spacing", 32'(cyc), 32'd2);
            chk("b2b ack0", {30'd0, ack1, ack0}, 32'd1);
            chk("b2b rdata0", rdata0, exp_rd[0]);
            if (k == 3) req0 = 0; else addr0 = 32'(k + 1);
        end
        tick();

        // Randomised rounds against the model
        for (int r = 0; r < 40; r++) begin
            rr0 = 1'($urandom_range(0, 1));
            rr1 = 1'($urandom_range(0, 1));
            if (!rr0 && !rr1) rr0 = 1'b1;
            do_round(rr0, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                     rr1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, "rand");
        end
        for (int i = 0; i < 256; i++)
            if (cur(i) !== ref_mem[i]) chk("final store", cur(i), ref_mem[i]);
        chk("final store word 0x10", cur(16), ref_mem[16]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
